main_ram_arb: RTL and testbench
===============================

Name: main_ram_arb

Overview:
- Parametrised, multi-port main RAM: N bus masters share one single-port byte-writable RAM through a round-robin arbiter.
- Generalises the single-port main RAM in three ways: data width, depth and port count are parameters; per-port req/ack handshake; configurable read latency with a per-port valid strobe.
- Sits between the video/CPU bus masters (CPU interface, layer renderers, sprite engine) and the RAM storage.

Parameters:
- NPORTS, 3, number of master ports (1..8).
- DATA_W, 32, data width; multiple of 8.
- DEPTH, 32768, RAM words; ADDR_W = clog2(DEPTH).
- RD_LATENCY, 1, cycles from ack to rd_valid; 1 or 2 (2 adds an output register).
- INIT_FILE, "", optional hex init file.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- bus_req  in  NPORTS  per-port access request, level.
- bus_write  in  NPORTS  per-port 1=write, 0=read.
- bus_addr  in  NPORTS*ADDR_W  per-port word address; port p occupies slice p.
- bus_wrdata  in  NPORTS*DATA_W  per-port write data.
- bus_wrbytesel  in  NPORTS*DATA_W/8  per-port byte enables.
- bus_ack  out  NPORTS  one-hot grant; access is performed this cycle.
- bus_rddata  out  DATA_W  shared read data.
- bus_rdvalid  out  NPORTS  one-hot; bus_rddata is valid for that port.

Behaviour:
- Reset values: bus_ack=0, bus_rdvalid=0, bus_rddata=0, round-robin pointer=0. RAM contents are not reset.
- Handshake:
  - Master raises bus_req[p] and holds req/write/addr/data/bytesel stable until it sees bus_ack[p]=1 on a clock edge.
  - Master may drop req or present a new request in the cycle after ack.
  - Ack without a sampled req is illegal; the bench asserts it never happens.
- Arbitration:
  - Combinational, at most one ack per cycle.
  - Candidates are searched from port ptr upward, with wrap-around.
  - On a grant to port g, ptr <= (g+1) mod NPORTS; with no request, ptr holds.
  - bus_ack is forced to 0 while reset=1.
- Access:
  - Granted write: bytes with bytesel=1 are written at the edge ending the ack cycle. bytesel=0 is a legal no-op write.
  - Write also returns data: rdvalid[g] pulses with the new word (write-first), so a master may ignore it.
  - Granted read: the RAM word is registered at the same edge.
- Latency:
  - RD_LATENCY=1: bus_rdvalid[g] and bus_rddata are asserted exactly one cycle after the ack cycle.
  - RD_LATENCY=2: they are asserted two cycles after.
  - rdvalid is a single-cycle pulse. bus_rddata holds its last value when no valid is asserted.
- Throughput: one access per cycle sustained. Back-to-back acks to different ports yield back-to-back rdvalids, in grant order.
- Same-address hazards: a read granted the cycle after a write to the same address returns the written data.
- Reset mid-operation: in-flight rdvalid pipeline entries are cleared; no valid is emitted for accesses acked before reset. Writes completed at an edge where reset=0 persist.
- Address ≥ DEPTH (non-power-of-2 depth): write is suppressed, read returns 0, ack/valid timing is unchanged.
- NPORTS=1: the arbiter degenerates to ack = req & ~reset.

Decomposition:
- Package main_ram_pkg:
  - Functions: clog2, port-slice index helpers.
  - Constants: BYTES = DATA_W/8, and the RD_LATENCY legal range.
- Sub-module rr_arbiter (NPORTS):
  - Inputs: req, clk, reset.
  - Outputs: one-hot grant and grant index.
  - Owns the pointer.
- RAM array and latency pipeline stay in the top module.

Test Plan:
- Reset, then port0 writes 0xDEADBEEF to addr 0x10 with bytesel 4'hF, then port0 reads 0x10 -> read ack, next cycle rdvalid=3'b001, rddata=0xDEADBEEF.
- Byte lanes: addr 0x20 holds 0x11223344; write 0xAABBCCDD with bytesel 4'b0101 -> read returns 0x11BB33DD.
- Fairness: all 3 ports hold read requests continuously for 9 cycles -> acks rotate 0,1,2,0,1,2…; each port gets exactly 3 acks; rdvalid order matches.
- Contention hold: port2 requests while port1 is granted -> port2 is acked the next cycle with its addr/data unchanged; no lost request.
- RD_LATENCY=2: read of 0x5 containing 0x12345678 -> rdvalid exactly 2 cycles after ack, single pulse.
- Reset mid-flight: read acked at cycle T, reset asserted at T+1 -> no rdvalid ever appears for it; post-reset ptr=0, so simultaneous requests from ports 1 and 2 grant port 1 first.

Source files
------------

// File: rtl/main_ram_pkg.sv
// Shared helpers for the multi-port main RAM: address sizing, port-slice
// offsets into the flattened bus vectors, and the legal read-latency range.
package main_ram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Byte lanes in a data word.
    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    // Low bit of port p's field inside a flattened per-port vector.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/main_ram_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from the
// pointer with wrap-around; the pointer moves just past each granted port.
module rr_arbiter
    import main_ram_pkg::*;
#(
    parameter  int NPORTS = 3,
    localparam int IDX_W  = (NPORTS > 1) ? clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Pick the first requesting port at or after the pointer; nothing during reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NPORTS);
            if (!found && req[cand]) begin
                found            = 1'b1;
                grant_idx        = cand;
                grant[cand]      = 1'b1;
            end
        end
        if (reset) begin
            grant     = '0;
            grant_idx = '0;
        end
    end

    // Advance the pointer past the winner; hold it on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == IDX_W'(NPORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/main_ram_arb.sv
// Multi-port main RAM: NPORTS masters share one byte-writable single-port RAM
// through a round-robin arbiter. Every granted access (read or write) returns
// the resulting word on the shared read bus after RD_LATENCY cycles, flagged
// by a one-hot per-port valid pulse.
module main_ram_arb
    import main_ram_pkg::*;
#(
    parameter  int NPORTS     = 3,
    parameter  int DATA_W     = 32,
    parameter  int DEPTH      = 32768,
    parameter  int RD_LATENCY = 1,
    parameter      INIT_FILE  = "",
    localparam int ADDR_W     = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int BYTES      = bytes_of(DATA_W),
    localparam int IDX_W      = (NPORTS > 1) ? clog2(NPORTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        bus_req,
    input  logic [NPORTS-1:0]        bus_write,
    input  logic [NPORTS*ADDR_W-1:0] bus_addr,
    input  logic [NPORTS*DATA_W-1:0] bus_wrdata,
    input  logic [NPORTS*BYTES-1:0]  bus_wrbytesel,
    output logic [NPORTS-1:0]        bus_ack,
    output logic [DATA_W-1:0]        bus_rddata,
    output logic [NPORTS-1:0]        bus_rdvalid
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NPORTS-1:0] grant;
    logic [IDX_W-1:0]  gidx;
    logic              any_grant;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BYTES-1:0]  sel_bsel;
    acc_kind_e         sel_kind;
    logic              in_range;

    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;

    logic [NPORTS-1:0] v1;
    logic [DATA_W-1:0] d1;
    logic [NPORTS-1:0] v_out;
    logic [DATA_W-1:0] d_out;

    rr_arbiter #(
        .NPORTS    (NPORTS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus_req),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign any_grant = |grant;
    assign bus_ack   = grant;

    // Route the winning port's request fields onto the RAM side.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_bsel  = '0;
        sel_kind  = ACC_READ;
        for (int p = 0; p < NPORTS; p++) begin
            if (gidx == IDX_W'(p)) begin
                sel_addr  = bus_addr[slice_lo(p, ADDR_W) +: ADDR_W];
                sel_wdata = bus_wrdata[slice_lo(p, DATA_W) +: DATA_W];
                sel_bsel  = bus_wrbytesel[slice_lo(p, BYTES) +: BYTES];
                sel_kind  = acc_kind_e'(bus_write[p]);
            end
        end
    end

    // Addresses past the end only exist when DEPTH is not a power of two.
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
        assign in_range = ({1'b0, sel_addr} < DEPTH_L);
    end

    // Preloading from INIT_FILE is handled by the target's memory-initialisation
    // flow; the parameter stays so existing instantiations elaborate unchanged.
    if (INIT_FILE != "") begin : g_init_file
    end

    assign mem_word = in_range ? mem[sel_addr] : '0;

    // Write-first view of the word: enabled byte lanes replaced by write data.
    always_comb begin
        merged = mem_word;
        for (int b = 0; b < BYTES; b++) begin
            if (sel_bsel[b]) begin
                merged[b*8 +: 8] = sel_wdata[b*8 +: 8];
            end
        end
    end

    assign rd_word = !in_range               ? '0     :
                     (sel_kind == ACC_WRITE) ? merged : mem_word;

    // Byte-lane writes land at the edge ending the ack cycle; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (any_grant && (sel_kind == ACC_WRITE) && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sel_bsel[b]) begin
                    mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // First return stage: capture the access result and the granted port.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= '0;
            d1 <= '0;
        end else begin
            v1 <= grant;
            if (any_grant) begin
                d1 <= rd_word;
            end
        end
    end

    if (RD_LATENCY >= RD_LAT_MAX) begin : g_lat2
        logic [NPORTS-1:0] v2;
        logic [DATA_W-1:0] d2;

        // Extra output register; data only moves when a valid moves with it.
        always_ff @(posedge clk) begin
            if (reset) begin
                v2 <= '0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (|v1) begin
                    d2 <= d1;
                end
            end
        end

        assign v_out = v2;
        assign d_out = d2;
    end else begin : g_lat1
        assign v_out = v1;
        assign d_out = d1;
    end

    // An access acked just before reset must never report valid, even in the reset cycle.
    assign bus_rdvalid = v_out & {NPORTS{~reset}};
    assign bus_rddata  = d_out;

endmodule

// File: tb/tb_main_ram_arb.sv
// Bench for main_ram_arb: two instances share one stimulus stream, one with
// a full power-of-two depth and 1-cycle latency, one with a partial depth and
// 2-cycle latency. A behavioural model (word maps, grant history keyed by
// cycle number) predicts acks, valids and read data every cycle.
module tb_main_ram_arb;

    localparam int NP = 3;
    localparam int DW = 32;
    localparam int AW = 15;
    localparam int D1 = 32768;
    localparam int D2 = 24576;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    bus_req;
    logic [NP-1:0]    bus_write;
    logic [NP*AW-1:0] bus_addr;
    logic [NP*DW-1:0] bus_wrdata;
    logic [NP*4-1:0]  bus_wrbytesel;
    logic [NP-1:0]    ack1, ack2, v1, v2;
    logic [DW-1:0]    rd1, rd2;

    always #5 clk = ~clk;

    main_ram_arb #(.NPORTS(NP), .DATA_W(DW), .DEPTH(D1), .RD_LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wrbytesel(bus_wrbytesel),
        .bus_ack(ack1), .bus_rddata(rd1), .bus_rdvalid(v1));

    main_ram_arb #(.NPORTS(NP), .DATA_W(DW), .DEPTH(D2), .RD_LATENCY(2), .INIT_FILE("")) dut2 (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wrbytesel(bus_wrbytesel),
        .bus_ack(ack2), .bus_rddata(rd2), .bus_rdvalid(v2));

    int n_tests = 0;
    int n_fail  = 0;

    // master-side request state
    logic          rst;
    logic [NP-1:0] p_req, p_wr, keep_req;
    logic [AW-1:0] p_addr [NP];
    logic [31:0]   p_data [NP];
    logic [3:0]    p_sel  [NP];

    // reference model
    logic [31:0] m1 [int];
    logic [31:0] m2 [int];
    int          gnt [int];
    logic [31:0] h1 [int];
    logic [31:0] h2 [int];
    int          cyc = 0;
    int          last_rst = -1000;
    int          ptr = 0;
    int          last_g;
    logic [31:0] exp_rd1, exp_rd2;

    // samples taken mid-cycle
    logic [NP-1:0] s_ack, s_v1, s_v2;
    logic [31:0]   s_d1, s_d2;

    int pool [8] = '{32'h10, 32'h20, 32'h5, 32'h30, 32'h5FFF, 32'h6000, 32'h7000, 32'h7FFF};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic issue(input int p, input bit wr, input int a, input logic [31:0] d, input logic [3:0] s);
        p_req[p]  = 1'b1;
        p_wr[p]   = wr;
        p_addr[p] = AW'(a);
        p_data[p] = d;
        p_sel[p]  = s;
    endtask

    // One clock cycle: drive, predict, compare at the falling edge, then advance the model.
    task automatic run_cycle();
        logic [NP-1:0] exp_ack, ev1, ev2;
        int a;
        logic [31:0] old_w, mw;
        reset   = rst;
        bus_req = p_req;
        bus_write = p_wr;
        for (int p = 0; p < NP; p++) begin
            bus_addr[p*AW +: AW]     = p_addr[p];
            bus_wrdata[p*DW +: DW]   = p_data[p];
            bus_wrbytesel[p*4 +: 4]  = p_sel[p];
        end
        @(negedge clk);
        cyc++;
        last_g  = -1;
        exp_ack = '0;
        if (rst) begin
            last_rst = cyc;
            ptr      = 0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                int c;
                c = (ptr + i) % NP;
                if (last_g < 0 && p_req[c]) last_g = c;
            end
        end
        if (last_g >= 0) exp_ack[last_g] = 1'b1;
        s_ack = ack1; s_v1 = v1; s_v2 = v2; s_d1 = rd1; s_d2 = rd2;
        chk("ack", ack1, exp_ack);
        chk("ack_dut2", ack2, exp_ack);
        chk("ack_without_req", ack1 & ~p_req, 0);
        ev1 = '0;
        ev2 = '0;
        if (gnt.exists(cyc - 1) && (cyc - 1) > last_rst) begin
            ev1[gnt[cyc - 1]] = 1'b1;
            exp_rd1 = h1[cyc - 1];
        end
        if (gnt.exists(cyc - 2) && (cyc - 2) > last_rst) begin
            ev2[gnt[cyc - 2]] = 1'b1;
            exp_rd2 = h2[cyc - 2];
        end
        chk("rdvalid_lat1", v1, ev1);
        chk("rdvalid_lat2", v2, ev2);
        if (!rst) begin
            chk("rddata_lat1", rd1, exp_rd1);
            chk("rddata_lat2", rd2, exp_rd2);
        end else begin
            exp_rd1 = '0;
            exp_rd2 = '0;
        end
        if (last_g >= 0) begin
            a     = int'(p_addr[last_g]);
            old_w = m1.exists(a) ? m1[a] : 32'h0;
            mw    = lane_merge(old_w, p_data[last_g], p_sel[last_g]);
            if (p_wr[last_g]) begin
                m1[a]    = mw;
                h1[cyc]  = mw;
            end else begin
                h1[cyc]  = old_w;
            end
            if (a >= D2) begin
                h2[cyc] = 32'h0;
            end else begin
                old_w = m2.exists(a) ? m2[a] : 32'h0;
                mw    = lane_merge(old_w, p_data[last_g], p_sel[last_g]);
                if (p_wr[last_g]) m2[a] = mw;
                h2[cyc] = p_wr[last_g] ? mw : old_w;
            end
            gnt[cyc] = last_g;
            ptr      = (last_g + 1) % NP;
        end
        @(posedge clk);
        #1;
        if (last_g >= 0 && !keep_req[last_g]) p_req[last_g] = 1'b0;
    endtask

    task automatic run_until_ack(input int p);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            run_cycle();
            if (last_g == p) done = 1'b1;
        end
        chk("ack_timeout", done, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int cnt [NP];
        rst      = 1'b1;
        p_req    = '0;
        p_wr     = '0;
        keep_req = '0;
        exp_rd1  = '0;
        exp_rd2  = '0;
        for (int p = 0; p < NP; p++) begin
            p_addr[p] = '0; p_data[p] = '0; p_sel[p] = '0;
        end

        // reset state
        idle(2);
        rst = 1'b0;
        run_cycle();
        chk("post_reset_ack", s_ack, 0);
        chk("post_reset_rdvalid", s_v1, 0);
        chk("post_reset_rddata", s_d1, 0);
        chk("post_reset_rddata2", s_d2, 0);

        // give every pool address a known full word
        foreach (pool[i]) begin
            issue(0, 1'b1, pool[i], $urandom, 4'hF);
            run_until_ack(0);
        end
        idle(2);

        // basic write then read
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        run_until_ack(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        run_until_ack(0);
        run_cycle();
        chk("basic_rdvalid", s_v1, 3'b001);
        chk("basic_rddata", s_d1, 32'hDEADBEEF);

        // byte lanes, read immediately after the partial write
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        run_until_ack(0);
        issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        run_until_ack(0);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        run_until_ack(0);
        run_cycle();
        chk("bytelane_rdvalid", s_v1, 3'b001);
        chk("bytelane_rddata", s_d1, 32'h11BB33DD);

        // two-cycle latency instance
        issue(0, 1'b1, 32'h5, 32'h12345678, 4'hF);
        run_until_ack(0);
        idle(3);
        issue(0, 1'b0, 32'h5, 32'h0, 4'h0);
        run_until_ack(0);
        run_cycle();
        chk("lat2_early", s_v2, 0);
        run_cycle();
        chk("lat2_valid", s_v2, 3'b001);
        chk("lat2_data", s_d2, 32'h12345678);
        run_cycle();
        chk("lat2_single_pulse", s_v2, 0);

        // address at/above the partial depth
        issue(0, 1'b1, 32'h6000, 32'h0BADF00D, 4'hF);
        run_until_ack(0);
        idle(3);
        issue(0, 1'b0, 32'h6000, 32'h0, 4'h0);
        run_until_ack(0);
        run_cycle();
        chk("oor_full_depth", s_d1, 32'h0BADF00D);
        run_cycle();
        chk("oor_valid", s_v2, 3'b001);
        chk("oor_zero", s_d2, 0);

        // fairness: all ports hold reads continuously after a reset
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        issue(2, 1'b0, 32'h5, 32'h0, 4'h0);
        keep_req = '1;
        rst = 1'b1;
        run_cycle();
        chk("reset_forces_ack", s_ack, 0);
        rst = 1'b0;
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int i = 0; i < 9; i++) begin
            run_cycle();
            chk("fair_order", s_ack, 64'(1) << (i % 3));
            if (last_g >= 0) cnt[last_g]++;
        end
        keep_req = '0;
        p_req    = '0;
        for (int p = 0; p < NP; p++) chk("fair_count", cnt[p], 3);
        idle(3);

        // contention: port2 waits one cycle behind port1
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        issue(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        run_cycle();
        chk("contend_first", s_ack, 3'b010);
        run_cycle();
        chk("contend_second", s_ack, 3'b100);
        issue(0, 1'b0, 32'h30, 32'h0, 4'h0);
        run_until_ack(0);
        run_cycle();
        chk("contend_data", s_d1, 32'hCAFEF00D);
        idle(2);

        // reset while a read is in flight
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0);
        run_until_ack(1);
        rst = 1'b1;
        run_cycle();
        chk("midflight_v1", s_v1, 0);
        rst = 1'b0;
        run_cycle();
        chk("midflight_v1_after", s_v1, 0);
        chk("midflight_v2_after", s_v2, 0);
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        issue(2, 1'b0, 32'h5, 32'h0, 4'h0);
        run_cycle();
        chk("post_reset_ptr", s_ack, 3'b010);
        run_cycle();
        chk("post_reset_next", s_ack, 3'b100);
        idle(3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!p_req[p] && ($urandom % 3 == 0)) begin
                    issue(p, 1'($urandom % 2), pool[$urandom % 8], $urandom, 4'($urandom));
                end
            end
            rst = ($urandom % 60 == 0);
            run_cycle();
        end
        rst = 1'b0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
